// File: rtl/ks_delay_pkg.sv
// rtl/ks_delay_pkg.sv - shared types, constants and length clamp for the voice delay lines
// Struct carries cfg_damp only when KS_DELAY_DAMP_EN is defined.
package ks_delay_pkg;

    localparam int MAX_AW  = 16;
    localparam int MIN_LEN = 4;

    // Fixed maximum widths so the struct stays independent of the module parameters.
    typedef logic [MAX_AW:0]   len_t;
    typedef logic [MAX_AW-1:0] ptr_t;
    typedef logic [MAX_AW+1:0] bcnt_t;

    typedef struct packed {
        ptr_t        ptr;
        bcnt_t       bcnt;
        logic        primed;
        len_t        cfg_len;
        logic [1:0]  cfg_octave;
`ifdef KS_DELAY_DAMP_EN
        logic [3:0]  cfg_damp;
`endif
        len_t        len_eff;
    } voice_state_t;

    function automatic len_t len_eff_clamp(input len_t len, input logic [1:0] octave, input len_t depth);
        len_t s;
        s = len >> octave;
        if (s < len_t'(MIN_LEN)) begin
            s = len_t'(MIN_LEN);
        end else if (s > depth) begin
            s = depth;
        end
        return s;
    endfunction

endpackage

// File: rtl/ks_voice_delay_if.sv
// rtl/ks_voice_delay_if.sv - sample slot stream into and delayed samples out of the voice delay
interface ks_voice_delay_if #(
    parameter int NUM_VOICES = 4,
    parameter int DATA_W     = 32,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
);
    logic                     in_valid;
    logic [VOICE_W-1:0]       in_voice;
    logic signed [DATA_W-1:0] dnoise;
    logic signed [DATA_W-1:0] dfilter;
    logic                     out_valid;
    logic [VOICE_W-1:0]       out_voice;
    logic signed [DATA_W-1:0] q;

    modport master (
        output in_valid, in_voice, dnoise, dfilter,
        input  out_valid, out_voice, q
    );

    modport slave (
        input  in_valid, in_voice, dnoise, dfilter,
        output out_valid, out_voice, q
    );
endinterface

// File: rtl/ks_delay_ram.sv
// rtl/ks_delay_ram.sv - single-port read-first RAM holding all voice delay lines
module ks_delay_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 12
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**AW];

    // Every accepted slot both reads the old sample and writes the new one.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_o      <= mem_q[addr_i];
            mem_q[addr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/ks_voice_delay.sv
// rtl/ks_voice_delay.sv - multi-voice Karplus-Strong delay lines with pluck bursts
// Optional per-voice feedback damping is enabled with KS_DELAY_DAMP_EN.
module ks_voice_delay
    import ks_delay_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_VOICES-1:0] trig,
    input  logic                  cfg_we,
    input  logic [VOICE_W-1:0]    cfg_voice,
    input  logic [ADDR_W:0]       cfg_len,
    input  logic [1:0]            cfg_octave,
`ifdef KS_DELAY_DAMP_EN
    input  logic [3:0]            cfg_damp,
`endif
    ks_voice_delay_if.slave       smp,
    output logic [NUM_VOICES-1:0] busy
);
    localparam len_t DEPTH = len_t'(1) << ADDR_W;

    voice_state_t             st_q [NUM_VOICES];
    voice_state_t             st_d [NUM_VOICES];
    voice_state_t             rst_st;
    len_t                     cfg_len_eff [NUM_VOICES];
    len_t                     act_len [NUM_VOICES];
    logic [NUM_VOICES-1:0]    hit;
    logic                     slot_burst;
    logic [ADDR_W-1:0]        slot_addr;
    logic signed [DATA_W-1:0] wdata;
    logic [DATA_W-1:0]        rdata;
    logic                     gate_q;
    logic                     out_valid_q;
    logic [VOICE_W-1:0]       out_voice_q;

    always_comb begin
        rst_st         = '0;
        rst_st.cfg_len = len_t'(MIN_LEN);
        rst_st.len_eff = len_t'(MIN_LEN);
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            st_d[v] = st_q[v];
            if (cfg_we && (cfg_voice == VOICE_W'(v))) begin
                st_d[v].cfg_len    = len_t'(cfg_len);
                st_d[v].cfg_octave = cfg_octave;
`ifdef KS_DELAY_DAMP_EN
                st_d[v].cfg_damp   = cfg_damp;
`endif
            end
            cfg_len_eff[v] = len_eff_clamp(st_d[v].cfg_len, st_d[v].cfg_octave, DEPTH);
            hit[v]         = smp.in_valid && (smp.in_voice == VOICE_W'(v));
            // A new length is picked up whenever a pass starts at address 0.
            act_len[v]     = (st_q[v].ptr == '0) ? cfg_len_eff[v] : st_q[v].len_eff;

            if (trig[v]) begin
                st_d[v].len_eff = cfg_len_eff[v];
                st_d[v].ptr     = hit[v] ? ptr_t'(1) : '0;
                st_d[v].bcnt    = hit[v] ? bcnt_t'({cfg_len_eff[v], 1'b0}) - bcnt_t'(1)
                                         : bcnt_t'({cfg_len_eff[v], 1'b0});
            end else if (hit[v]) begin
                st_d[v].len_eff = act_len[v];
                if (len_t'(st_q[v].ptr) == act_len[v] - len_t'(1)) begin
                    st_d[v].ptr    = '0;
                    st_d[v].primed = 1'b1;
                end else begin
                    st_d[v].ptr = st_q[v].ptr + ptr_t'(1);
                end
                if (st_q[v].bcnt != '0) begin
                    st_d[v].bcnt = st_q[v].bcnt - bcnt_t'(1);
                end
            end
        end

        slot_burst = trig[smp.in_voice] || (st_q[smp.in_voice].bcnt != '0);
        slot_addr  = trig[smp.in_voice] ? '0 : st_q[smp.in_voice].ptr[ADDR_W-1:0];
`ifdef KS_DELAY_DAMP_EN
        if (slot_burst) begin
            wdata = smp.dnoise;
        end else if (st_q[smp.in_voice].cfg_damp != '0) begin
            wdata = smp.dfilter - (smp.dfilter >>> st_q[smp.in_voice].cfg_damp);
        end else begin
            wdata = smp.dfilter;
        end
`else
        wdata = slot_burst ? smp.dnoise : smp.dfilter;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                st_q[v] <= rst_st;
            end
            busy        <= '0;
            out_valid_q <= 1'b0;
            out_voice_q <= '0;
            gate_q      <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                st_q[v] <= st_d[v];
                busy[v] <= (st_d[v].bcnt != '0);
            end
            out_valid_q <= smp.in_valid;
            if (smp.in_valid) begin
                out_voice_q <= smp.in_voice;
            end
            // Stale RAM contents stay hidden until the voice has completed one pass.
            gate_q <= smp.in_valid && st_q[smp.in_voice].primed;
        end
    end

    ks_delay_ram #(
        .DATA_W (DATA_W),
        .AW     (VOICE_W + ADDR_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (smp.in_valid && reset_n),
        .addr_i  ({smp.in_voice, slot_addr}),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign smp.out_valid = out_valid_q;
    assign smp.out_voice = out_voice_q;
    assign smp.q         = gate_q ? rdata : '0;
endmodule

// File: doc/ks_voice_delay.md
KS_VOICE_DELAY -- requirements
Module: ks_voice_delay

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_VOICES, 4, independent delay lines (power of 2, >= 2)
- DATA_W, 32, signed sample width
- ADDR_W, 10, log2 of per-voice depth (DEPTH = 2^ADDR_W)
- VOICE_W, $clog2(NUM_VOICES), voice index width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- trig  in  NUM_VOICES  one-cycle pluck pulse per voice, already debounced
- cfg_we  in  1  configuration write strobe
- cfg_voice  in  VOICE_W  voice being configured
- cfg_len  in  ADDR_W+1  base length in samples
- cfg_octave  in  2  right-shift applied to cfg_len
- in_valid  in  1  sample slot strobe
- in_voice  in  VOICE_W  voice of the slot
- dnoise  in  DATA_W  excitation sample
- dfilter  in  DATA_W  loop-filter feedback sample
- out_valid  out  1  delayed sample valid
- out_voice  out  VOICE_W  voice of q
- q  out  DATA_W  sample written len_eff slots earlier for out_voice
- busy  out  NUM_VOICES  excitation burst active per voice

Function
REQ-003 The effective length SHALL be len_eff = clamp(cfg_len >> cfg_octave, MIN_LEN = 4, DEPTH).
REQ-004 Each voice SHALL hold pointer ptr (0..len_eff-1), burst counter bcnt (ADDR_W+2 bits) and primed bit.
REQ-005 An accepted slot (in_valid=1) SHALL read and write RAM address {in_voice, ptr}, read-first, then advance ptr by 1 and wrap to 0 at len_eff-1.
REQ-006 The write value SHALL be dnoise while bcnt > 0 and dfilter otherwise; bcnt SHALL decrement per accepted slot while nonzero.
REQ-007 out_valid, out_voice and q SHALL be registered one cycle after the accepted slot (latency 1); in_valid MAY be high every cycle in any voice order.
REQ-008 q SHALL be 0 for a voice until its primed bit is set, which occurs on its first ptr wrap.
REQ-009 trig[v] SHALL set ptr_v = 0 and bcnt_v = 2*len_eff; it SHALL restart any burst in progress.
REQ-010 When trig[v] and an in_valid slot for v coincide, trig SHALL win: the slot writes dnoise at address 0, and the cycle ends with ptr_v = 1 and bcnt_v = 2*len_eff-1.
REQ-011 cfg_we SHALL update the voice's stored cfg_len/cfg_octave immediately, and the new len_eff SHALL take effect at the voice's next wrap or trig.
REQ-012 When cfg_we and trig coincide for the same voice, the trig SHALL use the new configuration.
REQ-013 busy[v] SHALL be (bcnt_v != 0), registered.

Reset
REQ-014 With reset_n=0 at a clk edge: all ptr=0, bcnt=0, primed=0, cfg_len=MIN_LEN, cfg_octave=0, out_valid=0, out_voice=0, q=0, busy=0.
REQ-015 Reset SHALL NOT clear RAM contents; primed gating (REQ-008) hides stale data.
REQ-016 Reset mid-burst SHALL abort the burst, and the first accepted slot after reset SHALL write dfilter.

Configuration
REQ-017 With macro KS_DELAY_DAMP_EN defined: add port cfg_damp (in, 4) stored per voice on cfg_we, reset 0.
- Non-burst write value = dfilter - (dfilter >>> cfg_damp) when cfg_damp != 0, else dfilter.
REQ-018 Without KS_DELAY_DAMP_EN: no cfg_damp port, no damping logic; dfilter is written unmodified.

Structure
REQ-019 Package ks_delay_pkg SHALL hold MIN_LEN, the per-voice state struct (ptr, bcnt, primed, cfg fields) and the len_eff clamp function.
REQ-020 Sub-module ks_delay_ram SHALL implement the NUM_VOICES*DEPTH x DATA_W read-first, one-cycle-read RAM; all other logic stays in ks_voice_delay.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Reset, cfg voice0 len=8 octave=0, 20 slots of dfilter=k, with no trig -> q=0 for slots 0..7, then q=k-8 from slot 8.
- Voice1 cfg_len=100 octave=2 (len_eff=25), trig, 60 slots -> busy high for exactly 50 slots; first 50 writes are dnoise; q after wrap equals dnoise of slot n-25.
- cfg_len=12 octave=3 (1 -> clamped to 4) -> delay of 4 slots; cfg_len=2047 -> clamped to 1024.
- trig and in_valid for voice2 in the same cycle -> address 0 written with dnoise, ptr=1, bcnt=2*len_eff-1.
- Interleaved voices 0..3 every cycle with distinct lengths 4/5/6/7 -> each q matches its own voice only; no cross-voice corruption.
- reset_n=0 mid-burst -> busy=0, out_valid=0 next cycle; q=0 until first wrap; with KS_DELAY_DAMP_EN, damp=1 and dfilter=1000 -> stored value 500.
